// File: rtl/hash_target_scan_if.sv
// Bus bundle between hash_target_scan and its controller/shared memory.
// slave is the scanner's view; master is the view of whatever drives it.
interface hash_target_scan_if;
  logic        start;
  logic [15:0] hash_out_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        mem_we;
  logic [15:0] memory_addr;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        found;
  logic [7:0]  first_nonce;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;

  modport slave (
    input  start, hash_out_addr, result_addr, target, memory_read_data,
    output done, mem_we, memory_addr, memory_write_data,
           found, first_nonce, best_nonce, best_hash
  );

  modport master (
    output start, hash_out_addr, result_addr, target, memory_read_data,
    input  done, mem_we, memory_addr, memory_write_data,
           found, first_nonce, best_nonce, best_hash
  );
endinterface

// File: rtl/hash_target_scan.sv
// Scans NUM_NONCES hash words from memory, finds the minimum and the first
// word below target, then writes a two-word result record back.
module hash_target_scan #(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_clk,
  hash_target_scan_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE0, WRITE1} state_e;

  localparam logic [8:0] N = 9'(NUM_NONCES);

  state_e      state_q, state_d;
  logic [8:0]  cyc_q, cyc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] res_addr_q, res_addr_d;
  logic [31:0] target_q, target_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] best_q, best_d;
  logic [7:0]  best_idx_q, best_idx_d;
  logic        found_q, found_d;
  logic [7:0]  first_idx_q, first_idx_d;
  logic        out_found_q, out_found_d;
  logic [7:0]  out_first_q, out_first_d;
  logic [7:0]  out_bidx_q, out_bidx_d;
  logic [31:0] out_best_q, out_best_d;
  logic [7:0]  cap_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      addr_q      <= '0;
      res_addr_q  <= '0;
      target_q    <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      best_q      <= '1;
      best_idx_q  <= '0;
      found_q     <= 1'b0;
      first_idx_q <= '0;
      out_found_q <= 1'b0;
      out_first_q <= '0;
      out_bidx_q  <= '0;
      out_best_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      addr_q      <= addr_d;
      res_addr_q  <= res_addr_d;
      target_q    <= target_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      found_q     <= found_d;
      first_idx_q <= first_idx_d;
      out_found_q <= out_found_d;
      out_first_q <= out_first_d;
      out_bidx_q  <= out_bidx_d;
      out_best_q  <= out_best_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    addr_d      = addr_q;
    res_addr_d  = res_addr_q;
    target_d    = target_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    found_d     = found_q;
    first_idx_d = first_idx_q;
    out_found_d = out_found_q;
    out_first_d = out_first_q;
    out_bidx_d  = out_bidx_q;
    out_best_d  = out_best_q;
    cap_idx     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d      = bus.hash_out_addr;
          res_addr_d  = bus.result_addr;
          target_d    = bus.target;
          we_d        = 1'b0;
          cyc_d       = '0;
          best_d      = '1;
          best_idx_d  = '0;
          found_d     = 1'b0;
          first_idx_d = '0;
          state_d     = READ;
        end
      end
      READ: begin
        // cyc_q counts READ edges; read data for address k lands at cyc_q = k+1
        cyc_d = cyc_q + 9'd1;
        if (cyc_q + 9'd1 < N) addr_d = addr_q + 16'd1;
        if (cyc_q != '0 && cyc_q <= N) begin
          cap_idx = 8'(cyc_q - 9'd1);
          if (bus.memory_read_data < best_q) begin
            best_d     = bus.memory_read_data;
            best_idx_d = cap_idx;
          end
          if (!found_q && bus.memory_read_data < target_q) begin
            found_d     = 1'b1;
            first_idx_d = cap_idx;
          end
        end
        if (cyc_q == N + 9'd1) begin
          we_d    = 1'b1;
          addr_d  = res_addr_q;
          wdata_d = {found_q, 23'b0, first_idx_q};
          state_d = WRITE0;
        end
      end
      WRITE0: begin
        addr_d  = res_addr_q + 16'd1;
        wdata_d = best_q;
        state_d = WRITE1;
      end
      WRITE1: begin
        we_d        = 1'b0;
        out_found_d = found_q;
        out_first_d = first_idx_q;
        out_bidx_d  = best_idx_q;
        out_best_d  = best_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_clk               = clk;
  assign bus.done              = (state_q == IDLE);
  assign bus.mem_we            = we_q;
  assign bus.memory_addr       = addr_q;
  assign bus.memory_write_data = wdata_q;
  assign bus.found             = out_found_q;
  assign bus.first_nonce       = out_first_q;
  assign bus.best_nonce        = out_bidx_q;
  assign bus.best_hash         = out_best_q;

endmodule

// File: tb/tb_hash_target_scan.sv
// Self-checking bench for hash_target_scan: directed table, random scans
// against a reference model, and reset/back-to-back/start-glitch sequences.
module tb_hash_target_scan;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_clk;
  always #5 clk = ~clk;

  hash_target_scan_if bus ();

  hash_target_scan #(.NUM_NONCES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mem_clk (mem_clk),
    .bus     (bus)
  );

  logic [31:0] hashmem [0:65535];
  logic [31:0] res_mem [0:65535];
  logic [31:0] rd_q;
  int unsigned wr_count = 0;

  always @(posedge mem_clk) begin
    rd_q <= hashmem[bus.memory_addr];
    if (bus.mem_we) begin
      res_mem[bus.memory_addr] <= bus.memory_write_data;
      wr_count <= wr_count + 1;
    end
  end
  assign bus.memory_read_data = rd_q;

  int vectors = 0;
  int miscompares = 0;

  logic        p_f;
  logic [7:0]  p_first, p_bidx;
  logic [31:0] p_best;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected scan result straight from the rules: global minimum, lowest
  // index holding it, lowest index strictly below target.
  function automatic void ref_scan(input logic [15:0][31:0] h, input logic [31:0] t,
                                   output logic f, output logic [7:0] fi,
                                   output logic [7:0] bi, output logic [31:0] b);
    b = h[0];
    for (int i = 1; i < 16; i++) if (h[i] < b) b = h[i];
    bi = '0;
    for (int i = 15; i >= 0; i--) if (h[i] == b) bi = 8'(i);
    f = 1'b0; fi = '0;
    for (int i = 15; i >= 0; i--) if (h[i] < t) begin f = 1'b1; fi = 8'(i); end
  endfunction

  task automatic run_scan(input string tag, input logic [15:0] base, input logic [15:0] res,
                          input logic [31:0] tgt, input logic [15:0][31:0] h,
                          input logic ef, input logic [7:0] efirst, input logic [7:0] ebidx,
                          input logic [31:0] ebest, input bit glitch);
    int we_bad = 0;
    int done_at = 0;
    int unsigned wc0;
    for (int i = 0; i < 16; i++) hashmem[16'(base + 16'(i))] = h[i];
    @(negedge clk);
    bus.hash_out_addr = base;
    bus.result_addr   = res;
    bus.target        = tgt;
    bus.start         = 1'b1;
    wc0 = wr_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, " done_fall"}, {31'b0, bus.done}, 32'd0);
    chk({tag, " addr_base"}, {16'b0, bus.memory_addr}, {16'b0, base});
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(posedge clk); #1;
      if (glitch && k == 5) bus.start = 1'b1;
      if (glitch && k == 6) bus.start = 1'b0;
      if (bus.mem_we !== (k == 18 || k == 19)) we_bad++;
      if (k == 18 && bus.memory_addr !== res) we_bad++;
      if (k == 19 && bus.memory_addr !== 16'(res + 16'd1)) we_bad++;
      if (k == 10)
        chk({tag, " outputs_held"}, bus.best_hash ^ {bus.found, 7'b0, bus.first_nonce, bus.best_nonce, 8'b0},
            p_best ^ {p_f, 7'b0, p_first, p_bidx, 8'b0});
      if (bus.done) done_at = k;
    end
    chk({tag, " done_cycle"}, done_at, 32'd20);
    chk({tag, " write_timing"}, we_bad, 32'd0);
    chk({tag, " found"}, {31'b0, bus.found}, {31'b0, ef});
    chk({tag, " first_nonce"}, {24'b0, bus.first_nonce}, {24'b0, efirst});
    chk({tag, " best_nonce"}, {24'b0, bus.best_nonce}, {24'b0, ebidx});
    chk({tag, " best_hash"}, bus.best_hash, ebest);
    chk({tag, " rec_word0"}, res_mem[res], {ef, 23'b0, efirst});
    chk({tag, " rec_word1"}, res_mem[16'(res + 16'd1)], ebest);
    @(posedge clk); #1;
    chk({tag, " stays_idle"}, {31'b0, bus.done}, 32'd1);
    chk({tag, " write_count"}, wr_count - wc0, 32'd2);
    p_f = ef; p_first = efirst; p_bidx = ebidx; p_best = ebest;
  endtask

  typedef struct {
    string            name;
    logic [15:0]      base;
    logic [15:0]      res;
    logic [31:0]      tgt;
    logic [15:0][31:0] h;
    logic             ef;
    logic [7:0]       efirst;
    logic [7:0]       ebidx;
    logic [31:0]      ebest;
    bit               glitch;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [15:0][31:0] rh;
    logic [31:0] rt;
    logic        mf;
    logic [7:0]  mfi, mbi;
    logic [31:0] mb;
    int unsigned wc0;
    int bad;
    int wecnt;

    for (int i = 0; i < 16; i++) begin
      tbl[0].h[i] = 32'h8000_0000 - 32'(i);
      tbl[1].h[i] = 32'hFFFF_0000;
      tbl[2].h[i] = 32'hFFFF_FFFF;
      tbl[3].h[i] = 32'hFFFF_FFFF;
      tbl[4].h[i] = 32'hFFFF_FFFF;
      tbl[5].h[i] = 32'hFFFF_FFFF;
    end
    tbl[0].name = "descend"; tbl[0].base = 16'h0100; tbl[0].res = 16'h0200; tbl[0].tgt = 32'h0;
    tbl[0].ef = 0; tbl[0].efirst = 0; tbl[0].ebidx = 15; tbl[0].ebest = 32'h7FFF_FFF1; tbl[0].glitch = 0;
    tbl[1].h[5] = 32'h0000_0FFF; tbl[1].h[9] = 32'h0000_0010;
    tbl[1].name = "found"; tbl[1].base = 16'h0300; tbl[1].res = 16'h0210; tbl[1].tgt = 32'h0000_1000;
    tbl[1].ef = 1; tbl[1].efirst = 5; tbl[1].ebidx = 9; tbl[1].ebest = 32'h10; tbl[1].glitch = 0;
    tbl[2].h[3] = 32'h1234_0000;
    tbl[2].name = "equal_tgt"; tbl[2].base = 16'h0400; tbl[2].res = 16'h0220; tbl[2].tgt = 32'h1234_0000;
    tbl[2].ef = 0; tbl[2].efirst = 0; tbl[2].ebidx = 3; tbl[2].ebest = 32'h1234_0000; tbl[2].glitch = 0;
    tbl[3].h[2] = 32'h1; tbl[3].h[7] = 32'h1;
    tbl[3].name = "tie"; tbl[3].base = 16'h0500; tbl[3].res = 16'h0230; tbl[3].tgt = 32'h0;
    tbl[3].ef = 0; tbl[3].efirst = 0; tbl[3].ebidx = 2; tbl[3].ebest = 32'h1; tbl[3].glitch = 1;
    tbl[4].name = "all_ones"; tbl[4].base = 16'h0600; tbl[4].res = 16'h0240; tbl[4].tgt = 32'h0;
    tbl[4].ef = 0; tbl[4].efirst = 0; tbl[4].ebidx = 0; tbl[4].ebest = 32'hFFFF_FFFF; tbl[4].glitch = 0;
    tbl[5].h[0] = 32'h0000_0100; tbl[5].h[12] = 32'h0000_0042;
    tbl[5].name = "wrap"; tbl[5].base = 16'hFFF8; tbl[5].res = 16'h0250; tbl[5].tgt = 32'h0000_0200;
    tbl[5].ef = 1; tbl[5].efirst = 0; tbl[5].ebidx = 12; tbl[5].ebest = 32'h42; tbl[5].glitch = 0;

    bus.start = 1'b0; bus.hash_out_addr = '0; bus.result_addr = '0; bus.target = '0;
    p_f = 0; p_first = 0; p_bidx = 0; p_best = 0;

    #12;
    chk("rst done", {31'b0, bus.done}, 32'd1);
    chk("rst mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst addr", {16'b0, bus.memory_addr}, 32'd0);
    chk("rst wdata", bus.memory_write_data, 32'd0);
    chk("rst results", {bus.found, 7'b0, bus.first_nonce, bus.best_nonce, 8'b0} | bus.best_hash, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_scan(tbl[v].name, tbl[v].base, tbl[v].res, tbl[v].tgt, tbl[v].h,
               tbl[v].ef, tbl[v].efirst, tbl[v].ebidx, tbl[v].ebest, tbl[v].glitch);

    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 16; i++)
        rh[i] = ($urandom_range(3) == 0) ? 32'($urandom_range(3000)) : $urandom;
      if (j % 2 == 0) rh[$urandom_range(15)] = rh[$urandom_range(15)];
      rt = (j % 3 == 0) ? $urandom : 32'($urandom_range(2000));
      ref_scan(rh, rt, mf, mfi, mbi, mb);
      run_scan("random", 16'(32'h1000 + 32'(j) * 32'h40), 16'(32'h4000 + 32'(j) * 2), rt, rh,
               mf, mfi, mbi, mb, 0);
    end

    // Reset during READ: immediate idle, cleared results, no writes afterwards.
    for (int i = 0; i < 16; i++) hashmem[16'(16'h0700 + 16'(i))] = 32'h5;
    @(negedge clk);
    bus.hash_out_addr = 16'h0700; bus.result_addr = 16'h0260; bus.target = 32'hFFFF_FFFF;
    bus.start = 1'b1;
    wc0 = wr_count;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    chk("midrst done", {31'b0, bus.done}, 32'd1);
    chk("midrst mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("midrst results", {bus.found, 7'b0, bus.first_nonce, bus.best_nonce, 8'b0} | bus.best_hash, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst no_writes", wr_count - wc0, 32'd0);
    chk("midrst idle", {31'b0, bus.done}, 32'd1);
    p_f = 0; p_first = 0; p_bidx = 0; p_best = 0;
    run_scan("post_rst", tbl[1].base, 16'h0270, tbl[1].tgt, tbl[1].h,
             tbl[1].ef, tbl[1].efirst, tbl[1].ebidx, tbl[1].ebest, 0);

    // start held high: scans every 21 edges, done high one cycle between.
    @(negedge clk);
    bus.result_addr = 16'h0280;
    bus.start = 1'b1;
    bad = 0; wecnt = 0;
    wc0 = wr_count;
    for (int c = 1; c <= 63; c++) begin
      @(posedge clk); #1;
      if (bus.done !== (c % 21 == 0)) bad++;
      if (bus.mem_we) wecnt++;
      if (c == 63) bus.start = 1'b0;
    end
    chk("b2b done_pattern", bad, 32'd0);
    chk("b2b we_cycles", wecnt, 32'd6);
    chk("b2b write_count", wr_count - wc0, 32'd6);
    chk("b2b best_hash", bus.best_hash, tbl[1].ebest);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
